// File: rtl/myproject_mac_accum_if.sv
// Product-in / result-out stream bundle for the MAC accumulator.
// slave is the accumulator's view, master the producer/consumer side.
interface myproject_mac_accum_if #(
    parameter int PROD_WIDTH = 8,
    parameter int BIAS_WIDTH = 8,
    parameter int OUT_WIDTH  = 8
);
    logic [PROD_WIDTH-1:0] prod_data;
    logic                  prod_valid;
    logic                  prod_ready;
    logic [BIAS_WIDTH-1:0] bias;
    logic [OUT_WIDTH-1:0]  out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [7:0]            term_cnt;

    modport master (
        output prod_data, prod_valid, bias, out_ready,
        input  prod_ready, out_data, out_valid, term_cnt
    );

    modport slave (
        input  prod_data, prod_valid, bias, out_ready,
        output prod_ready, out_data, out_valid, term_cnt
    );
endinterface

// File: rtl/myproject_mac_accum.sv
// Windowed signed MAC accumulator: bias + N_TERMS products, >>> SHIFT, saturate.
// Optional fused ReLU before saturation when MYPROJECT_ACC_RELU_EN is defined.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_ACCUM  | accepting product terms, prod_ready=1, out_valid=0
// S_OUTPUT | result held on out_data, out_valid=1, waiting for out_ready
module myproject_mac_accum #(
    parameter int PROD_WIDTH = 8,
    parameter int N_TERMS    = 9,
    parameter int ACC_WIDTH  = 16,
    parameter int BIAS_WIDTH = 8,
    parameter int SHIFT      = 0,
    parameter int OUT_WIDTH  = 8
) (
    input logic               ap_clk,
    input logic               ap_rst_n,
    myproject_mac_accum_if.slave bus
);

    typedef enum logic {
        S_ACCUM  = 1'b0,
        S_OUTPUT = 1'b1
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(N_TERMS - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    state_t                      state_q;
    state_t                      state_d;
    logic [7:0]                  term_cnt_q;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic [OUT_WIDTH-1:0]        out_q;

    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] bias_ext;
    logic signed [ACC_WIDTH-1:0] base;
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [ACC_WIDTH-1:0] shifted;
    logic signed [ACC_WIDTH-1:0] act;
    logic signed [ACC_WIDTH-1:0] sat;
    logic                        accept;
    logic                        last;

    assign prod_ext = ACC_WIDTH'($signed(bus.prod_data));
    assign bias_ext = ACC_WIDTH'($signed(bus.bias));

    // The first term of a window starts from the bias instead of the stale sum.
    assign base    = (term_cnt_q == 8'd0) ? bias_ext : acc_q;
    assign sum     = base + prod_ext;
    assign shifted = sum >>> SHIFT;

`ifdef MYPROJECT_ACC_RELU_EN
    assign act = shifted[ACC_WIDTH-1] ? '0 : shifted;
`else
    assign act = shifted;
`endif

    always_comb begin
        sat = act;
        if (act > SAT_MAX) begin
            sat = SAT_MAX;
        end else if (act < SAT_MIN) begin
            sat = SAT_MIN;
        end
    end

    assign accept = (state_q == S_ACCUM) && bus.prod_valid;
    assign last   = (term_cnt_q == LAST_IDX);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= S_ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        bus.prod_ready = 1'b0;
        bus.out_valid  = 1'b0;
        case (state_q)
            S_ACCUM: begin
                bus.prod_ready = 1'b1;
                if (accept && last) begin
                    state_d = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = S_ACCUM;
                end
            end
            default: state_d = S_ACCUM;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc_q      <= '0;
            term_cnt_q <= 8'd0;
            out_q      <= '0;
        end else if (accept) begin
            acc_q <= sum;
            if (last) begin
                term_cnt_q <= 8'd0;
                out_q      <= OUT_WIDTH'(sat);
            end else begin
                term_cnt_q <= term_cnt_q + 8'd1;
            end
        end
    end

    assign bus.out_data = out_q;
    assign bus.term_cnt = term_cnt_q;

endmodule
